// File: rtl/int_controller.sv
// Prioritising interrupt controller: edge-captures IRQ/NMIsrc into pending flags and
// presents one request at a time to the CPU. Optional IE mask port under INTC_MASK_EN.
module int_controller #(
    parameter int unsigned NUM_SRC  = 8,
    parameter int unsigned BASE_VEC = 48,
    parameter int unsigned NMI_VEC  = 62
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] IRQ,
    input  logic               NMIsrc,
    input  logic               INTACK,
`ifdef INTC_MASK_EN
    input  logic [NUM_SRC-1:0] IE,
`endif
    output logic               NMI,
    output logic               INT,
    output logic [5:0]         IntAddrLSBs,
    output logic [NUM_SRC-1:0] IRQACK,
    output logic [NUM_SRC-1:0] Pending
);

    localparam int unsigned SEL_W = 4;
    localparam int unsigned VEC_W = 6;
    localparam logic [VEC_W-1:0] RST_VEC = 6'd63;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]         r_state;
    logic [SEL_W-1:0]   r_sel;
    logic               r_sel_nmi;
    logic               r_int;
    logic               r_nmi;
    logic [VEC_W-1:0]   r_vec;
    logic [NUM_SRC-1:0] r_irqack;
    logic [NUM_SRC-1:0] r_pending;
    logic               r_nmi_pend;
    logic [NUM_SRC-1:0] r_irq_d;
    logic               r_nmi_d;

    logic [1:0]         w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               w_sel_nmi_nxt;
    logic               w_int_nxt;
    logic               w_nmi_nxt;
    logic [VEC_W-1:0]   w_vec_nxt;
    logic [NUM_SRC-1:0] w_irqack_nxt;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_nmi_clr;
    logic [NUM_SRC-1:0] w_elig;
    logic [SEL_W-1:0]   w_pick;
    logic [NUM_SRC-1:0] w_sel_oh;
    logic [NUM_SRC-1:0] w_irq_rise;
    logic               w_nmi_rise;

    assign w_irq_rise = IRQ & ~r_irq_d;
    assign w_nmi_rise = NMIsrc & ~r_nmi_d;
    assign w_sel_oh   = NUM_SRC'(1) << r_sel;

`ifdef INTC_MASK_EN
    assign w_elig = r_pending & IE;
`else
    assign w_elig = r_pending;
`endif

    // Highest eligible index wins: later iterations overwrite earlier ones.
    always_comb begin
        w_pick = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_elig[i]) begin
                w_pick = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_sel_nmi_nxt = r_sel_nmi;
        w_int_nxt     = r_int;
        w_nmi_nxt     = r_nmi;
        w_vec_nxt     = r_vec;
        w_irqack_nxt  = '0;
        w_clr         = '0;
        w_nmi_clr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_int_nxt = 1'b0;
                w_nmi_nxt = 1'b0;
                w_vec_nxt = RST_VEC;
                if (r_nmi_pend) begin
                    w_state_nxt   = S_REQ;
                    w_sel_nmi_nxt = 1'b1;
                    w_nmi_nxt     = 1'b1;
                    w_vec_nxt     = VEC_W'(NMI_VEC);
                end else if (|w_elig) begin
                    w_state_nxt   = S_REQ;
                    w_sel_nxt     = w_pick;
                    w_sel_nmi_nxt = 1'b0;
                    w_int_nxt     = 1'b1;
                    w_vec_nxt     = VEC_W'(BASE_VEC) + VEC_W'(w_pick);
                end
            end
            S_REQ: begin
                // Request is frozen here; new arrivals only accumulate in pending.
                if (INTACK) begin
                    w_state_nxt = S_ACK;
                    w_int_nxt   = 1'b0;
                    w_nmi_nxt   = 1'b0;
                    w_vec_nxt   = RST_VEC;
                    if (r_sel_nmi) begin
                        w_nmi_clr = 1'b1;
                    end else begin
                        w_clr        = w_sel_oh;
                        w_irqack_nxt = w_sel_oh;
                    end
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_int_nxt   = 1'b0;
                w_nmi_nxt   = 1'b0;
                w_vec_nxt   = RST_VEC;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_int_nxt   = 1'b0;
                w_nmi_nxt   = 1'b0;
                w_vec_nxt   = RST_VEC;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_sel_nmi <= 1'b0;
            r_int     <= 1'b0;
            r_nmi     <= 1'b0;
            r_vec     <= RST_VEC;
            r_irqack  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_sel_nmi <= w_sel_nmi_nxt;
            r_int     <= w_int_nxt;
            r_nmi     <= w_nmi_nxt;
            r_vec     <= w_vec_nxt;
            r_irqack  <= w_irqack_nxt;
        end
    end

    // Edge registers track inputs even in reset so release creates no false edge; set beats clear.
    always_ff @(posedge MCLK) begin
        r_irq_d <= IRQ;
        r_nmi_d <= NMIsrc;
        if (reset) begin
            r_pending  <= '0;
            r_nmi_pend <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clr) | w_irq_rise;
            r_nmi_pend <= (r_nmi_pend & ~w_nmi_clr) | w_nmi_rise;
        end
    end

    assign NMI         = r_nmi;
    assign INT         = r_int;
    assign IntAddrLSBs = r_vec;
    assign IRQACK      = r_irqack;
    assign Pending     = r_pending;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed vector table, hand sequences, then random
// stimulus against a behavioural model. Mask tests run when INTC_MASK_EN is defined.
module tb_int_controller;

    localparam int unsigned NS   = 8;
    localparam int          NONE = -2;
    localparam int          NMID = -1;

    logic          MCLK;
    logic          reset;
    logic [NS-1:0] IRQ;
    logic          NMIsrc;
    logic          INTACK;
    logic [NS-1:0] IE;
    logic          NMI;
    logic          INT;
    logic [5:0]    IntAddrLSBs;
    logic [NS-1:0] IRQACK;
    logic [NS-1:0] Pending;

    int n_checks = 0;
    int n_pass   = 0;

    int_controller #(.NUM_SRC(NS), .BASE_VEC(48), .NMI_VEC(62)) dut (
        .MCLK(MCLK),
        .reset(reset),
        .IRQ(IRQ),
        .NMIsrc(NMIsrc),
        .INTACK(INTACK),
`ifdef INTC_MASK_EN
        .IE(IE),
`endif
        .NMI(NMI),
        .INT(INT),
        .IntAddrLSBs(IntAddrLSBs),
        .IRQACK(IRQACK),
        .Pending(Pending)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    function automatic logic [31:0] pk(input logic i, input logic n, input logic [5:0] v,
                                       input logic [7:0] a, input logic [7:0] p);
        return {8'h00, i, n, v, a, p};
    endfunction

    function automatic logic [31:0] obs();
        return pk(INT, NMI, IntAddrLSBs, IRQACK, Pending);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {INT,NMI,vec,ack,pend}=%h expected %h", name, got, exp);
    endtask

    task automatic cyc(input string name, input logic [31:0] exp);
        @(posedge MCLK);
        #1;
        check(name, obs(), exp);
    endtask

    // Behavioural model: which source is being presented, and how many idle cycles follow an ack.
    logic [NS-1:0] m_pend;
    logic          m_npend;
    logic [NS-1:0] m_ack;
    logic [NS-1:0] m_irq_prev;
    logic          m_nmi_prev;
    int            m_pres;
    int            m_hold;

    task automatic model_step();
        logic [NS-1:0] rise;
        logic          nrise;
        bit            found;
        m_ack = '0;
        if (reset) begin
            m_pend  = '0;
            m_npend = 1'b0;
            m_pres  = NONE;
            m_hold  = 0;
        end else begin
            rise  = IRQ & ~m_irq_prev;
            nrise = NMIsrc & ~m_nmi_prev;
            if (m_pres != NONE) begin
                if (INTACK) begin
                    if (m_pres == NMID) m_npend = 1'b0;
                    else begin
                        m_pend[m_pres] = 1'b0;
                        m_ack[m_pres]  = 1'b1;
                    end
                    m_pres = NONE;
                    m_hold = 1;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (m_npend) begin
                m_pres = NMID;
            end else begin
                found = 0;
                for (int i = NS - 1; i >= 0; i--) begin
                    if (!found && m_pend[i] && IE[i]) begin
                        m_pres = i;
                        found  = 1;
                    end
                end
            end
            m_pend  = m_pend | rise;
            m_npend = m_npend | nrise;
        end
        m_irq_prev = IRQ;
        m_nmi_prev = NMIsrc;
    endtask

    function automatic logic [31:0] model_pack();
        logic [5:0] v;
        if (m_pres == NMID) v = 6'd62;
        else if (m_pres >= 0) v = 6'(48 + m_pres);
        else v = 6'd63;
        return pk(m_pres >= 0, m_pres == NMID, v, m_ack, m_pend);
    endfunction

    typedef struct {
        logic          rst;
        logic [NS-1:0] irq;
        logic          ack;
        logic [31:0]   exp;
    } vec_t;

    vec_t tbl[22];

    initial begin
        reset  = 1'b1;
        IRQ    = '0;
        NMIsrc = 1'b0;
        INTACK = 1'b0;
        IE     = '1;

        tbl[0]  = '{1'b1, 8'h00, 1'b0, pk(0, 0, 63, 8'h00, 8'h00)};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, pk(0, 0, 63, 8'h00, 8'h00)};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, pk(0, 0, 63, 8'h00, 8'h00)};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, pk(0, 0, 63, 8'h00, 8'h00)};
        tbl[4]  = '{1'b0, 8'h04, 1'b0, pk(0, 0, 63, 8'h00, 8'h04)};
        tbl[5]  = '{1'b0, 8'h04, 1'b0, pk(1, 0, 50, 8'h00, 8'h04)};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, pk(1, 0, 50, 8'h00, 8'h04)};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, pk(0, 0, 63, 8'h04, 8'h00)};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, pk(0, 0, 63, 8'h00, 8'h00)};
        tbl[9]  = '{1'b0, 8'h22, 1'b0, pk(0, 0, 63, 8'h00, 8'h22)};
        tbl[10] = '{1'b0, 8'h22, 1'b0, pk(1, 0, 53, 8'h00, 8'h22)};
        tbl[11] = '{1'b0, 8'h22, 1'b1, pk(0, 0, 63, 8'h20, 8'h02)};
        tbl[12] = '{1'b0, 8'h00, 1'b0, pk(0, 0, 63, 8'h00, 8'h02)};
        tbl[13] = '{1'b0, 8'h00, 1'b0, pk(1, 0, 49, 8'h00, 8'h02)};
        tbl[14] = '{1'b0, 8'h00, 1'b1, pk(0, 0, 63, 8'h02, 8'h00)};
        tbl[15] = '{1'b0, 8'h00, 1'b0, pk(0, 0, 63, 8'h00, 8'h00)};
        tbl[16] = '{1'b0, 8'h08, 1'b0, pk(0, 0, 63, 8'h00, 8'h08)};
        tbl[17] = '{1'b0, 8'h00, 1'b0, pk(1, 0, 51, 8'h00, 8'h08)};
        tbl[18] = '{1'b0, 8'h08, 1'b0, pk(1, 0, 51, 8'h00, 8'h08)};
        tbl[19] = '{1'b0, 8'h08, 1'b1, pk(0, 0, 63, 8'h08, 8'h00)};
        tbl[20] = '{1'b0, 8'h00, 1'b0, pk(0, 0, 63, 8'h00, 8'h00)};
        tbl[21] = '{1'b0, 8'h00, 1'b0, pk(0, 0, 63, 8'h00, 8'h00)};

        for (int r = 0; r < 22; r++) begin
            reset  = tbl[r].rst;
            IRQ    = tbl[r].irq;
            INTACK = tbl[r].ack;
            @(posedge MCLK);
            #1;
            check($sformatf("table_row%0d", r), obs(), tbl[r].exp);
        end
        INTACK = 1'b0;

        // NMI arriving while a maskable request is presented waits its turn.
        IRQ = 8'h08;                   cyc("nmi_pre_pend", pk(0, 0, 63, 8'h00, 8'h08));
        cyc("nmi_pre_req", pk(1, 0, 51, 8'h00, 8'h08));
        NMIsrc = 1'b1;                 cyc("nmi_hold1", pk(1, 0, 51, 8'h00, 8'h08));
        cyc("nmi_hold2", pk(1, 0, 51, 8'h00, 8'h08));
        INTACK = 1'b1;                 cyc("nmi_src3_ack", pk(0, 0, 63, 8'h08, 8'h00));
        INTACK = 1'b0;                 cyc("nmi_idle", pk(0, 0, 63, 8'h00, 8'h00));
        cyc("nmi_req", pk(0, 1, 62, 8'h00, 8'h00));
        INTACK = 1'b1;                 cyc("nmi_ack", pk(0, 0, 63, 8'h00, 8'h00));
        INTACK = 1'b0; NMIsrc = 1'b0; IRQ = 8'h00;
        cyc("nmi_after1", pk(0, 0, 63, 8'h00, 8'h00));
        cyc("nmi_after2", pk(0, 0, 63, 8'h00, 8'h00));

        // New edge coincident with the clearing ack: set wins.
        IRQ = 8'h01;                   cyc("sw_pend", pk(0, 0, 63, 8'h00, 8'h01));
        cyc("sw_req", pk(1, 0, 48, 8'h00, 8'h01));
        IRQ = 8'h00;                   cyc("sw_release", pk(1, 0, 48, 8'h00, 8'h01));
        IRQ = 8'h01; INTACK = 1'b1;    cyc("sw_ack", pk(0, 0, 63, 8'h01, 8'h01));
        INTACK = 1'b0;                 cyc("sw_idle", pk(0, 0, 63, 8'h00, 8'h01));
        cyc("sw_rereq", pk(1, 0, 48, 8'h00, 8'h01));

        // Reset in REQ and in ACK.
        reset = 1'b1;                  cyc("rst_req", pk(0, 0, 63, 8'h00, 8'h00));
        reset = 1'b0;                  cyc("rst_noedge1", pk(0, 0, 63, 8'h00, 8'h00));
        cyc("rst_noedge2", pk(0, 0, 63, 8'h00, 8'h00));
        IRQ = 8'h00;                   cyc("rst_low", pk(0, 0, 63, 8'h00, 8'h00));
        IRQ = 8'h80;                   cyc("rst_pend7", pk(0, 0, 63, 8'h00, 8'h80));
        cyc("rst_req7", pk(1, 0, 55, 8'h00, 8'h80));
        INTACK = 1'b1;                 cyc("rst_ack7", pk(0, 0, 63, 8'h80, 8'h00));
        INTACK = 1'b0; IRQ = 8'h00; NMIsrc = 1'b1;
        reset = 1'b1;                  cyc("rst_in_ack", pk(0, 0, 63, 8'h00, 8'h00));
        reset = 1'b0;                  cyc("rst_nmi_noedge", pk(0, 0, 63, 8'h00, 8'h00));
        cyc("rst_nmi_noedge2", pk(0, 0, 63, 8'h00, 8'h00));
        NMIsrc = 1'b0;

`ifdef INTC_MASK_EN
        IE = 8'h00; IRQ = 8'h10;       cyc("mask_pend", pk(0, 0, 63, 8'h00, 8'h10));
        cyc("mask_hold1", pk(0, 0, 63, 8'h00, 8'h10));
        cyc("mask_hold2", pk(0, 0, 63, 8'h00, 8'h10));
        IE = 8'h10;                    cyc("mask_enable", pk(1, 0, 52, 8'h00, 8'h10));
        IE = 8'h00;                    cyc("mask_nowithdraw", pk(1, 0, 52, 8'h00, 8'h10));
        reset = 1'b1;                  cyc("mask_rst_req", pk(0, 0, 63, 8'h00, 8'h00));
        reset = 1'b0; IE = 8'hFF; IRQ = 8'h00;
        cyc("mask_after", pk(0, 0, 63, 8'h00, 8'h00));
`endif

        // Random traffic against the model; first cycle is a reset to sync it.
        for (int c = 0; c < 3000; c++) begin
            reset = (c == 0) || ($urandom_range(0, 299) == 0);
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(0, 9) == 0) IRQ[b] = ~IRQ[b];
            end
            if ($urandom_range(0, 19) == 0) NMIsrc = ~NMIsrc;
            if (m_pres != NONE && c != 0) INTACK = ($urandom_range(0, 2) == 0);
            else INTACK = ($urandom_range(0, 24) == 0);
`ifdef INTC_MASK_EN
            if ($urandom_range(0, 15) == 0) IE = 8'($urandom);
`endif
            @(posedge MCLK);
            model_step();
            #1;
            check($sformatf("rand_c%0d", c), obs(), model_pack());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Prioritising interrupt controller between peripheral IRQ lines and the CPU interrupt inputs (NMI, INT, IntAddrLSBs, INTACK).
- Edge-captures requests into pending flags and selects the highest-priority source.
- Presents a stable vector index to the CPU until INTACK, then clears the serviced flag and reports it to the source.

Parameters:
- NUM_SRC, 8: number of maskable IRQ sources (1..14).
- BASE_VEC, 48: IntAddrLSBs index of source 0; source i maps to BASE_VEC+i (BASE_VEC+NUM_SRC-1 must be <= 61).
- NMI_VEC, 62: IntAddrLSBs index for the NMI (vector FFFC).

Ports:
- MCLK  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- IRQ  in  NUM_SRC  peripheral request lines; rising edge sets pending.
- NMIsrc  in  1  non-maskable request; rising edge sets NMI pending.
- INTACK  in  1  CPU acknowledge; one-cycle pulse when the CPU fetches the vector.
- NMI  out  1  to CPU; high while the NMI is being requested.
- INT  out  1  to CPU; high while a maskable interrupt is being requested.
- IntAddrLSBs  out  6  vector index to CPU (vector address = FFC0 + 2*index).
- IRQACK  out  NUM_SRC  one-hot, one-cycle pulse to the serviced source.
- Pending  out  NUM_SRC  current pending flags, for debug and peripheral status.

Behaviour:
Reset (reset=1 at a rising edge):
- Pending=0, NMI pending=0, IRQ/NMIsrc edge registers loaded with current inputs (no spurious edge on release).
- State=IDLE, INT=0, NMI=0, IRQACK=0, IntAddrLSBs=63 (reset vector FFFE).

Edge capture:
- Pending[i] is set the cycle after IRQ[i] goes 0->1.
- If a set and a clear of the same flag occur in the same cycle, set wins and the flag stays pending.

Priority:
- NMI pending beats all maskable sources.
- Among eligible sources, the higher index wins.

State machine:
- IDLE:
  - INT=0, NMI=0, IntAddrLSBs=63.
  - If NMI pending: latch sel=NMI and go to REQ.
  - Else if any eligible source is pending: latch sel=highest eligible index and go to REQ.
  - INTACK in IDLE (e.g. the CPU's reset-vector fetch) is ignored.
- REQ:
  - IntAddrLSBs = NMI_VEC or BASE_VEC+sel, registered.
  - NMI=1 when sel is NMI, else INT=1.
  - Vector and sel are frozen; new or higher-priority requests (including NMI) only accumulate in pending.
  - On INTACK: go to ACK.
- ACK (one cycle):
  - INT=0, NMI=0, IntAddrLSBs=63.
  - Clear the pending flag for sel; IRQACK[sel]=1 if sel is maskable (NMI has no IRQACK bit).
  - Next state: IDLE.

Latency:
- IRQ edge at cycle n gives pending at n+1, INT/vector valid at n+2.
- INTACK at cycle m gives IRQACK and pending clear at m+1; the next request can be presented at m+2.

Boundary cases:
- Source released before INTACK: stays pending and is still serviced (edge-latched).
- Repeated edges on an already-pending source collapse into one service.
- reset mid-REQ or mid-ACK: immediate return to reset values; no IRQACK pulse.

Optional Feature:
- Macro: INTC_MASK_EN.
- Defined:
  - Adds input port IE (width NUM_SRC); source i is eligible only when Pending[i]&IE[i].
  - Masked sources still set Pending and are serviced once unmasked.
  - Changing IE while in REQ does not withdraw the presented request.
- Undefined:
  - No IE port; every pending source is eligible.

Test Plan:
1. Release reset, no IRQ -> INT=0, NMI=0, IntAddrLSBs=63. An INTACK pulse in IDLE -> no state change and IRQACK=0.
2. IRQ[2] rises at cycle 10 -> INT=1, IntAddrLSBs=50 at cycle 12. INTACK at cycle 15 -> IRQACK=8'b0000_0100 and Pending[2]=0 at cycle 16; INT=0 at cycle 16.
3. IRQ[1] and IRQ[5] rise together -> vector 53 served first; after its ACK, vector 49 presented two cycles later.
4. In REQ for source 3, NMIsrc rises -> vector 51 is held until INTACK. Then NMI=1 with IntAddrLSBs=62; INTACK -> NMI=0 and no IRQACK bit set.
5. IRQ[0] rises in the same cycle the ACK clears Pending[0] -> Pending[0] stays 1 and vector 48 is re-presented.
6. INTC_MASK_EN, IE=8'h00, IRQ[4] rises -> Pending[4]=1, INT stays 0. Set IE[4]=1 -> INT=1 and IntAddrLSBs=52 next cycle. Separately, reset asserted in REQ -> INT=0 and Pending=0 the next cycle.
